uart_alu_interface: RTL

- Controller that sequences the UART receiver, the ALU and the UART transmitter.
- Collects three bytes from UART_RX in a fixed order: operand A, operand B, opcode.
- Drives the ALU, latches the result and hands it to the transmitter as one byte, then waits for transmit completion.
- Sits between UART_RX/UART_TX (ticked by BR_GENERATOR) and the ALU in the top level.

---
 rtl/uart_alu_interface_pkg.sv | 37 +++
 rtl/uart_alu_interface_edge_detect_pulse.sv | 28 ++
 rtl/uart_alu_interface.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART/ALU sequencer: default widths, FSM state
// encodings and the ALU opcode set.
package uart_alu_interface_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned OP_W_DEF   = 6;

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_START   = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    localparam logic [OP_W_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W_DEF-1:0] OP_SRL = 6'b000010;

    function automatic logic is_valid_op(input logic [OP_W_DEF-1:0] op);
        logic valid;
        valid = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: valid = 1'b1;
            default:                        valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/uart_alu_interface_edge_detect_pulse.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
module uart_alu_interface_edge_detect_pulse (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_level,
    output logic o_pulse
);

    logic level_q;
    logic level_d;

    // Next value of the delayed level is simply the current level.
    always_comb begin
        level_d = i_level;
    end

    // Delayed copy of the level; cleared on reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign o_pulse = i_level & ~level_q;

endmodule

// File: rtl/uart_alu_interface.sv
// Sequencer between UART_RX, the ALU and UART_TX: gathers A, B and opcode,
// latches the ALU result and launches one transmit byte per frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_WAIT_A  | idle, waiting for operand A byte
// S_WAIT_B  | waiting for operand B byte
// S_WAIT_OP | waiting for opcode byte; invalid opcode goes straight to TX
// S_EXEC    | one settle cycle for the combinational ALU, capture result
// S_START   | o_tx_start high for this single cycle
// S_WAIT_TX | waiting for a fresh rising edge of i_tx_done
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       OP_W     = OP_W_DEF,
    parameter logic [DATA_W-1:0] ERR_CODE = 8'hFF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_tx_done,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    output logic              o_tx_start,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_busy,
    output logic              o_error
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              error_q, error_d;
    logic              rx_pulse;
    logic              tx_pulse;

    uart_alu_interface_edge_detect_pulse u_rx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_level (i_rx_done),
        .o_pulse (rx_pulse)
    );

    uart_alu_interface_edge_detect_pulse u_tx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_level (i_tx_done),
        .o_pulse (tx_pulse)
    );

    // Next-state and datapath capture; bytes arriving outside the three
    // collection states are dropped on purpose, nothing is buffered.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        error_d   = error_q;
        case (state_q)
            S_WAIT_A: begin
                if (rx_pulse) begin
                    alu_a_d = i_rx_data;
                    error_d = 1'b0;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (rx_pulse) begin
                    alu_b_d = i_rx_data;
                    state_d = S_WAIT_OP;
                end
            end
            S_WAIT_OP: begin
                if (rx_pulse) begin
                    alu_op_d = i_rx_data[OP_W-1:0];
                    if (is_valid_op(i_rx_data[OP_W-1:0])) begin
                        state_d = S_EXEC;
                    end else begin
                        error_d   = 1'b1;
                        tx_data_d = ERR_CODE;
                        state_d   = S_START;
                    end
                end
            end
            S_EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = S_START;
            end
            S_START: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_pulse) begin
                    state_d = S_WAIT_A;
                end
            end
            default: begin
                state_d = S_WAIT_A;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= S_WAIT_A;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            error_q   <= error_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_error    = error_q;
    assign o_tx_start = (state_q == S_START);
    assign o_busy     = (state_q != S_WAIT_A);

endmodule
